// File: rtl/midi_voice_table.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | midi_voice_table: MIDI byte parser feeding a four-slot held-note table |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module midi_voice_table #(
  parameter int CHANNEL = 0,
  parameter int OMNI    = 1
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic [7:0]  midi_byte_in,
  input  logic        midi_byte_valid_in,
  output logic [4:0]  on_array_out,
  output logic [15:0] midi_burst_data_out [4:0],
  output logic        midi_burst_change_out,
  output logic [2:0]  voice_count_out,
  output logic        dropped_note_out,
  output logic        overrun_out
);

  localparam logic [2:0] c_WAIT_STATUS = 3'd0;
  localparam logic [2:0] c_WAIT_D1     = 3'd1;
  localparam logic [2:0] c_WAIT_D2     = 3'd2;
  localparam logic [2:0] c_SKIP        = 3'd3;
  localparam logic [2:0] c_UPDATE      = 3'd4;

  localparam logic [3:0] c_CHANNEL     = CHANNEL[3:0];
  localparam logic [3:0] c_NOTE_OFF    = 4'h8;
  localparam logic [3:0] c_NOTE_ON     = 4'h9;
  localparam logic [3:0] c_CTRL        = 4'hB;
  localparam logic [7:0] c_ALL_OFF     = 8'd123;

  logic [2:0]  r_state_q, w_state_d;
  logic [3:0]  r_status_q, w_status_d;
  logic [7:0]  r_d1_q, w_d1_d;
  logic [7:0]  r_d2_q, w_d2_d;
  logic [4:0]  r_on_q, w_on_d;
  logic [15:0] r_data_q [4:0];
  logic [15:0] w_data_d [4:0];
  logic        r_change_q, w_change_d;
  logic        r_dropped_q, w_dropped_d;
  logic        r_overrun_q, w_overrun_d;

  logic        w_is_rt, w_is_status, w_is_data, w_chan_ok, w_voice_msg;
  logic        w_match_hit, w_free_hit;
  logic [2:0]  w_match_idx, w_free_idx;
  logic        w_note_on, w_note_off;
  logic [2:0]  w_count;

  assign w_is_rt     = midi_byte_valid_in && (midi_byte_in >= 8'hF8);
  assign w_is_status = midi_byte_valid_in && midi_byte_in[7] && !w_is_rt;
  assign w_is_data   = midi_byte_valid_in && !midi_byte_in[7];
  assign w_chan_ok   = (OMNI != 0) || (midi_byte_in[3:0] == c_CHANNEL);
  assign w_voice_msg = w_chan_ok && ((midi_byte_in[7:4] == c_NOTE_OFF) ||
                                     (midi_byte_in[7:4] == c_NOTE_ON) ||
                                     (midi_byte_in[7:4] == c_CTRL));

  assign w_note_on  = (r_status_q == c_NOTE_ON) && (r_d2_q != 8'd0);
  assign w_note_off = (r_status_q == c_NOTE_OFF) ||
                      ((r_status_q == c_NOTE_ON) && (r_d2_q == 8'd0));

  // Descending scans so the lowest matching/free slot wins; slot 0 is never searched.
  always_comb begin
    w_match_hit = 1'b0;
    w_match_idx = 3'd0;
    w_free_hit  = 1'b0;
    w_free_idx  = 3'd0;
    for (int i = 4; i >= 1; i--) begin
      if (r_on_q[i] && (r_data_q[i][15:8] == r_d1_q)) begin
        w_match_hit = 1'b1;
        w_match_idx = i[2:0];
      end
      if (!r_on_q[i]) begin
        w_free_hit = 1'b1;
        w_free_idx = i[2:0];
      end
    end
  end

  always_comb begin
    w_state_d   = r_state_q;
    w_status_d  = r_status_q;
    w_d1_d      = r_d1_q;
    w_d2_d      = r_d2_q;
    w_on_d      = r_on_q;
    w_data_d    = r_data_q;
    w_change_d  = 1'b0;
    w_dropped_d = 1'b0;
    w_overrun_d = 1'b0;

    if (r_state_q == c_UPDATE) begin
      w_state_d   = c_WAIT_D1;
      w_overrun_d = midi_byte_valid_in && !w_is_rt;
      if (w_note_on) begin
        if (w_match_hit) begin
          w_data_d[w_match_idx][7:0] = r_d2_q;
          w_change_d                 = 1'b1;
        end else if (w_free_hit) begin
          w_data_d[w_free_idx] = {r_d1_q, r_d2_q};
          w_on_d[w_free_idx]   = 1'b1;
          w_change_d           = 1'b1;
        end else begin
          w_dropped_d = 1'b1;
        end
      end else if (w_note_off) begin
        if (w_match_hit) begin
          w_data_d[w_match_idx] = 16'd0;
          w_on_d[w_match_idx]   = 1'b0;
          w_change_d            = 1'b1;
        end
      end else if ((r_status_q == c_CTRL) && (r_d1_q == c_ALL_OFF)) begin
        w_on_d     = 5'd0;
        w_change_d = |r_on_q;
        for (int i = 0; i < 5; i++) begin
          w_data_d[i] = 16'd0;
        end
      end
    end else if (w_is_status) begin
      if (w_voice_msg) begin
        w_status_d = midi_byte_in[7:4];
        w_state_d  = c_WAIT_D1;
      end else begin
        w_status_d = 4'd0;
        w_state_d  = c_SKIP;
      end
    end else if (w_is_data) begin
      if (r_state_q == c_WAIT_D1) begin
        w_d1_d    = midi_byte_in;
        w_state_d = c_WAIT_D2;
      end else if (r_state_q == c_WAIT_D2) begin
        w_d2_d    = midi_byte_in;
        w_state_d = c_UPDATE;
      end
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      r_state_q   <= c_WAIT_STATUS;
      r_status_q  <= 4'd0;
      r_d1_q      <= 8'd0;
      r_d2_q      <= 8'd0;
      r_on_q      <= 5'd0;
      r_data_q    <= '{default: 16'd0};
      r_change_q  <= 1'b0;
      r_dropped_q <= 1'b0;
      r_overrun_q <= 1'b0;
    end else begin
      r_state_q   <= w_state_d;
      r_status_q  <= w_status_d;
      r_d1_q      <= w_d1_d;
      r_d2_q      <= w_d2_d;
      r_on_q      <= w_on_d;
      r_data_q    <= w_data_d;
      r_change_q  <= w_change_d;
      r_dropped_q <= w_dropped_d;
      r_overrun_q <= w_overrun_d;
    end
  end

  always_comb begin
    w_count = 3'd0;
    for (int i = 0; i < 5; i++) begin
      w_count = w_count + {2'b00, r_on_q[i]};
    end
  end

  assign on_array_out          = r_on_q;
  assign midi_burst_data_out   = r_data_q;
  assign midi_burst_change_out = r_change_q;
  assign voice_count_out       = w_count;
  assign dropped_note_out      = r_dropped_q;
  assign overrun_out           = r_overrun_q;

endmodule
`default_nettype wire
